// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared fetch-stage types and constants
package if_fetch_pkg;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic RST_ENABLE = 1'b1;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;
    localparam logic [INST_ADDR_W-1:0] IF_RESET_PC = 32'h0000_0000;
    typedef enum logic [2:0] {F0, F1, F2, F3, F4, HOLD} fetch_state_t;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory bus plus IF/ID handover signals
interface if_fetch_if;
    import if_fetch_pkg::*;
    logic stall_i;
    logic branch_flag_i;
    logic [INST_ADDR_W-1:0] branch_target_i;
    logic mem_req_o;
    logic [INST_ADDR_W-1:0] mem_addr_o;
    logic [7:0] mem_rdata_i;
    logic [INST_ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic valid_o;
    modport master (
        input stall_i, branch_flag_i, branch_target_i, mem_rdata_i,
        output mem_req_o, mem_addr_o, pc_o, inst_o, valid_o
    );
    modport slave (
        output stall_i, branch_flag_i, branch_target_i, mem_rdata_i,
        input mem_req_o, mem_addr_o, pc_o, inst_o, valid_o
    );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: PC owner; assembles each instruction from 4 little-endian byte reads
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = IF_RESET_PC
) (
    input logic clk,
    input logic rst,
    if_fetch_if.master bus
);
    fetch_state_t state, state_nx;
    logic [INST_ADDR_W-1:0] pc, pc_q;
    logic [INST_W-1:0] inst_q;
    logic [7:0] b0, b1, b2;
    logic [1:0] off;
    logic valid_q;
    always_comb begin
        state_nx = state;
        state_nx = bus.branch_flag_i ? F0 :
                   state == F0 ? F1 :
                   state == F1 ? F2 :
                   state == F2 ? F3 :
                   state == F3 ? F4 :
                   state == F4 ? HOLD :
                   bus.stall_i ? HOLD : F0;
        off = state == F1 ? 2'd1 : state == F2 ? 2'd2 : state == F3 ? 2'd3 : 2'd0;
    end
    assign bus.mem_req_o = state != F4 && state != HOLD;
    assign bus.mem_addr_o = pc + INST_ADDR_W'(off);
    assign bus.pc_o = pc_q;
    assign bus.inst_o = inst_q;
    assign bus.valid_o = valid_q;
    // Each captured byte is the one addressed in the previous state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state <= F0;
            pc <= RESET_PC;
            pc_q <= ZERO_WORD;
            inst_q <= ZERO_WORD;
            valid_q <= 1'b0;
            b0 <= '0;
            b1 <= '0;
            b2 <= '0;
        end else begin
            state <= state_nx;
            if (bus.branch_flag_i) begin
                pc <= {bus.branch_target_i[INST_ADDR_W-1:2], 2'b00};
                valid_q <= 1'b0;
            end else begin
                if (state == F1) b0 <= bus.mem_rdata_i;
                if (state == F2) b1 <= bus.mem_rdata_i;
                if (state == F3) b2 <= bus.mem_rdata_i;
                if (state == F4) begin
                    inst_q <= {bus.mem_rdata_i, b2, b1, b0};
                    pc_q <= pc + 32'd4;
                    valid_q <= 1'b1;
                end
                if (state == HOLD && !bus.stall_i) begin
                    valid_q <= 1'b0;
                    pc <= pc + 32'd4;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for the byte-serial fetch stage
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    bit prev_valid = 1'b0;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb[$];
    if_fetch_if bus();
    if_fetch dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [7:0] mb(input logic [31:0] a);
        logic [7:0] tbl [4];
        tbl = '{8'h13, 8'h05, 8'h50, 8'h00};
        return (a < 32'd4) ? tbl[a[1:0]] : (a[7:0] ^ 8'h3C ^ a[31:24] ^ {a[11:8], a[15:12]});
    endfunction
    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction
    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc = a + 32'd4;
        e.inst = exp_inst(a);
        sb.push_back(e);
    endtask
    always @(posedge clk) bus.mem_rdata_i <= mb(bus.mem_addr_o);
    always @(negedge clk) begin
        exp_t e;
        if (bus.valid_o && !prev_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc_o=%h inst_o=%h, none expected", bus.pc_o, bus.inst_o);
            end else begin
                e = sb.pop_front();
                if (bus.pc_o !== e.pc || bus.inst_o !== e.inst) begin
                    errors++;
                    $display("FAIL sb_inst: got pc_o=%h inst_o=%h, expected pc_o=%h inst_o=%h",
                             bus.pc_o, bus.inst_o, e.pc, e.inst);
                end
            end
        end
        prev_valid = bus.valid_o;
    end
    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.valid_o;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: valid_o=0 after 20 cycles, expected 1", name);
        end
    endtask
    task automatic test_reset;
        bus.stall_i = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.inst_o !== 32'h0 || bus.pc_o !== 32'h0 ||
            bus.mem_addr_o !== 32'h0 || bus.mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b inst=%h pc=%h addr=%h req=%b, expected 0 0 0 0 1",
                     bus.valid_o, bus.inst_o, bus.pc_o, bus.mem_addr_o, bus.mem_req_o);
        end
        rst = 1'b0;
        push(32'h0);
    endtask
    task automatic test_basic;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                checks++;
                if (bus.valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early: valid_o=%b after 4 edges, expected 0", bus.valid_o);
                end
            end
        end
        checks++;
        if (bus.valid_o !== 1'b1 || bus.inst_o !== 32'h0050_0513 || bus.pc_o !== 32'h4) begin
            errors++;
            $display("FAIL basic_first: valid=%b inst=%h pc=%h, expected 1 00500513 00000004",
                     bus.valid_o, bus.inst_o, bus.pc_o);
        end
        push(32'h4);
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h4) begin
            errors++;
            $display("FAIL basic_next: valid=%b req=%b addr=%h, expected 0 1 00000004",
                     bus.valid_o, bus.mem_req_o, bus.mem_addr_o);
        end
    endtask
    task automatic test_stall;
        wait_valid("stall");
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h8 || bus.inst_o !== exp_inst(32'h4) ||
                bus.mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b pc=%h inst=%h req=%b, expected 1 00000008 %h 0",
                         bus.valid_o, bus.pc_o, bus.inst_o, bus.mem_req_o, exp_inst(32'h4));
            end
        end
        bus.stall_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h8) begin
            errors++;
            $display("FAIL stall_release: valid=%b req=%b addr=%h, expected 0 1 00000008",
                     bus.valid_o, bus.mem_req_o, bus.mem_addr_o);
        end
    endtask
    task automatic test_branch;
        @(negedge clk);
        @(negedge clk);
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h100;
        push(32'h100);
        @(negedge clk);
        bus.branch_flag_i = 1'b0;
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL branch_f2: req=%b addr=%h, expected 1 00000100", bus.mem_req_o, bus.mem_addr_o);
        end
        wait_valid("branch");
    endtask
    task automatic test_branch_stall;
        bus.branch_flag_i = 1'b1;
        bus.stall_i = 1'b1;
        bus.branch_target_i = 32'h203;
        push(32'h200);
        @(negedge clk);
        bus.branch_flag_i = 1'b0;
        bus.stall_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h200) begin
            errors++;
            $display("FAIL branch_stall: valid=%b req=%b addr=%h, expected 0 1 00000200",
                     bus.valid_o, bus.mem_req_o, bus.mem_addr_o);
        end
        wait_valid("branch_stall");
    endtask
    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h207) begin
            errors++;
            $display("FAIL rst_mid_f3: req=%b addr=%h, expected 1 00000207", bus.mem_req_o, bus.mem_addr_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.inst_o !== 32'h0 || bus.pc_o !== 32'h0 || bus.mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: valid=%b inst=%h pc=%h addr=%h, expected 0 0 0 0",
                     bus.valid_o, bus.inst_o, bus.pc_o, bus.mem_addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        push(32'h0);
        #1;
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_restart: req=%b addr=%h, expected 1 00000000", bus.mem_req_o, bus.mem_addr_o);
        end
        wait_valid("rst_restart");
    endtask
    task automatic test_wrap;
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC);
        @(negedge clk);
        bus.branch_flag_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'hFFFF_FFFC + 32'(k)) begin
                errors++;
                $display("FAIL wrap_addr%0d: req=%b addr=%h, expected 1 %h",
                         k, bus.mem_req_o, bus.mem_addr_o, 32'hFFFF_FFFC + 32'(k));
            end
            @(negedge clk);
        end
        wait_valid("wrap");
        @(negedge clk);
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: req=%b addr=%h, expected 1 00000000", bus.mem_req_o, bus.mem_addr_o);
        end
    endtask
    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_branch;
        test_branch_stall;
        test_reset_mid;
        test_wrap;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Owns the PC and reads each 32-bit instruction from a byte-wide synchronous instruction memory as 4 little-endian byte reads.
- Presents the assembled instruction, with the sequential PC (fetch address + 4), to the IF/ID boundary.
- Decode relies on the PC convention: it computes the AUIPC base as pc_i - 4.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset (`RstEnable = 1'b1).
stall_i  input  1  downstream hold; 1 blocks handover of the held instruction.
branch_flag_i  input  1  redirect request from a later stage.
branch_target_i  input  32  redirect address; bits [1:0] ignored (treated as 0).
mem_req_o  output  1  read request to instruction memory this cycle.
mem_addr_o  output  32  byte address for this cycle's read.
mem_rdata_i  input  8  byte for the address presented in the previous cycle (1-cycle latency).
pc_o  output  32  fetch address + 4 of the held instruction.
inst_o  output  32  assembled instruction.
valid_o  output  1  pc_o/inst_o hold a complete instruction.

Behaviour:
- Registers: pc (fetch address), state, byte buffer b0..b2, inst_o, pc_o, valid_o.
- Reset (async, while rst=1):
  - pc=RESET_PC, state=F0.
  - inst_o=`ZeroWord, pc_o=`ZeroWord, valid_o=0.
  - Outputs reach these values immediately on rst assertion, not at the next edge.
- States and transitions:
  - F0: mem_req_o=1, mem_addr_o=pc. Next state F1.
  - F1: mem_req_o=1, mem_addr_o=pc+1. Capture mem_rdata_i into b0. Next state F2.
  - F2: mem_req_o=1, mem_addr_o=pc+2. Capture b1. Next state F3.
  - F3: mem_req_o=1, mem_addr_o=pc+3. Capture b2. Next state F4.
  - F4: mem_req_o=0.
    - At the edge: inst_o={mem_rdata_i,b2,b1,b0}, pc_o=pc+4, valid_o=1.
    - Next state HOLD.
  - HOLD: mem_req_o=0.
    - If stall_i=0: the instruction is consumed at this edge; valid_o<=0, pc<=pc+4, next state F0.
    - If stall_i=1: stay in HOLD; inst_o, pc_o and valid_o stay stable.
- mem_addr_o equals pc whenever mem_req_o=0.
- Latency and throughput:
  - valid_o rises on the 5th rising edge after the first F0 cycle.
  - Unstalled throughput is 1 instruction per 6 cycles.
  - No overlap between instructions.
- Redirect (branch_flag_i=1 at an edge, in any state):
  - pc<={branch_target_i[31:2],2'b00}, state<=F0, valid_o<=0.
  - Any partial bytes are discarded.
  - Redirect overrides both stall_i and the F4 completion.
  - A redirect in HOLD drops the held instruction even while stalled.
- Simultaneous events:
  - branch_flag_i wins over stall_i and over completion.
  - stall_i outside HOLD has no effect: fetching continues to HOLD, then waits.
- Address arithmetic is 32-bit modulo: pc=32'hFFFF_FFFC yields byte addresses FFFF_FFFC..FFFF_FFFF and pc_o=32'h0000_0000.
- Reset asserted mid-fetch aborts immediately; fetch restarts at RESET_PC in F0 after release.
- inst_o is never partially updated: it changes only at the F4 edge or on reset.

Decomposition:
- Add to the shared define include: the state encodings (F0..F4, HOLD as 3-bit `define constants) and `IfResetPc.
- Reuse the existing `InstAddrBus, `InstBus, `RstEnable and `ZeroWord.
- No sub-module is natural; the FSM, PC register and byte assembler are one module.

Test Plan:
- Reset, memory[0..3]=13 05 50 00, stall_i=0 -> first F0 cycle has mem_addr_o=0; valid_o=1 on the 5th edge with inst_o=32'h0050_0513, pc_o=32'h4; the next F0 presents mem_addr_o=4.
- Hold stall_i=1 for 3 cycles once valid_o=1 -> inst_o/pc_o/valid_o stable and mem_req_o=0 throughout; on release, the next edge drops valid_o and the next F0 cycle has mem_addr_o=4.
- Pulse branch_flag_i in F2 with target 32'h100 -> next state F0 with mem_addr_o=32'h100; the next valid instruction is assembled from bytes 100..103 only, with pc_o=32'h104.
- branch_flag_i=1 and stall_i=1 together in HOLD, target 32'h203 -> valid_o=0 at the next edge; fetch restarts at 32'h200.
- Assert rst in F3 -> valid_o and inst_o clear immediately (async); after release, mem_addr_o=RESET_PC.
- pc forced to 32'hFFFF_FFFC via redirect -> byte addresses FFFF_FFFC..FFFF_FFFF and pc_o=32'h0; the following fetch starts at 0.
